// File: rtl/spi_txn_sequencer.sv
// Feeds the single-CS SPI controller: buffers TX bytes, issues one byte per TX handshake,
// counts returned RX bytes and reports completion, rejection or WAIT_RX timeout.
module spi_txn_sequencer #(
  parameter  int MAX_BYTES_PER_CS = 2,
  parameter  int FIFO_DEPTH       = 4,
  parameter  int TIMEOUT_CLKS     = 256,
  localparam int CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Cmd_Valid,
  input  logic [CW-1:0] i_Cmd_Count,
  output logic          o_Cmd_Ready,
  output logic          o_Cmd_Err,
  input  logic [7:0]    i_Wr_Byte,
  input  logic          i_Wr_DV,
  output logic          o_Wr_Full,
  output logic          o_Wr_Overflow,
  output logic [CW-1:0] o_TX_Count,
  output logic [7:0]    o_TX_Byte,
  output logic          o_TX_DV,
  input  logic          i_TX_Ready,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte,
  output logic [7:0]    o_Rd_Byte,
  output logic          o_Rd_DV,
  output logic          o_Done,
  output logic          o_Timeout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_BYTES_PER_CS);
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_WAIT_RX,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   tx_count_q, tx_count_d;
  logic [CW-1:0]   recv_q, recv_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_dv_q, tx_dv_d;
  logic [7:0]      rd_byte_q, rd_byte_d;
  logic            rd_dv_q, rd_dv_d;
  logic            cmd_err_q, cmd_err_d;
  logic            timeout_q, timeout_d;
  logic            wr_ovf_q, wr_ovf_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     fill_q, fill_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];

  logic fifo_full, fifo_empty, push, pop, flush;

  assign fifo_full  = (fill_q == DEPTH_C);
  assign fifo_empty = (fill_q == '0);
  assign push       = i_Wr_DV && !fifo_full;

  // Flush on timeout wins over a same-cycle push: the aborted transaction's data is discarded.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    wr_ovf_d = i_Wr_DV && fifo_full;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = i_Wr_Byte;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   fill_d = fill_q + (PW + 1)'(1);
        2'b01:   fill_d = fill_q - (PW + 1)'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_count_d = tx_count_q;
    recv_d     = recv_q;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;
    rd_byte_d  = rd_byte_q;
    rd_dv_d    = 1'b0;
    cmd_err_d  = 1'b0;
    timeout_d  = 1'b0;
    wait_d     = wait_q;
    pop        = 1'b0;
    flush      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_Cmd_Valid) begin
          if ((i_Cmd_Count != '0) && (i_Cmd_Count <= MAX_C)) begin
            tx_count_d = i_Cmd_Count;
            recv_d     = '0;
            state_d    = S_WAIT_DATA;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_WAIT_DATA: begin
        if (!fifo_empty && i_TX_Ready) begin
          pop       = 1'b1;
          tx_byte_d = mem_q[rd_ptr_q];
          tx_dv_d   = 1'b1;
          wait_d    = '0;
          state_d   = S_WAIT_RX;
        end
      end
      S_WAIT_RX: begin
        if (i_RX_DV) begin
          rd_byte_d = i_RX_Byte;
          rd_dv_d   = 1'b1;
          recv_d    = recv_q + CW'(1);
          state_d   = ((recv_q + CW'(1)) == tx_count_q) ? S_DONE : S_WAIT_DATA;
        end else if (TIMEOUT_CLKS != 0) begin
          // wait_q counts completed WAIT_RX cycles; the pulse lands TIMEOUT_CLKS cycles after entry
          if (wait_q == TW'(TIMEOUT_CLKS - 1)) begin
            timeout_d = 1'b1;
            flush     = 1'b1;
            state_d   = S_IDLE;
          end else begin
            wait_d = wait_q + TW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= S_IDLE;
      tx_count_q <= '0;
      recv_q     <= '0;
      tx_byte_q  <= '0;
      tx_dv_q    <= 1'b0;
      rd_byte_q  <= '0;
      rd_dv_q    <= 1'b0;
      cmd_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      wr_ovf_q   <= 1'b0;
      wait_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      tx_count_q <= tx_count_d;
      recv_q     <= recv_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      rd_byte_q  <= rd_byte_d;
      rd_dv_q    <= rd_dv_d;
      cmd_err_q  <= cmd_err_d;
      timeout_q  <= timeout_d;
      wr_ovf_q   <= wr_ovf_d;
      wait_q     <= wait_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      mem_q      <= mem_d;
    end
  end

  assign o_Cmd_Ready   = (state_q == S_IDLE);
  assign o_Cmd_Err     = cmd_err_q;
  assign o_Wr_Full     = fifo_full;
  assign o_Wr_Overflow = wr_ovf_q;
  assign o_TX_Count    = tx_count_q;
  assign o_TX_Byte     = tx_byte_q;
  assign o_TX_DV       = tx_dv_q;
  assign o_Rd_Byte     = rd_byte_q;
  assign o_Rd_DV       = rd_dv_q;
  // DONE lasts one cycle and is entered on the same edge as the final o_Rd_DV
  assign o_Done        = (state_q == S_DONE);
  assign o_Timeout     = timeout_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Bench for spi_txn_sequencer with a behavioural stand-in for the SPI controller.
module tb_spi_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, wr_dv, tx_ready, rx_dv;
  logic [1:0] cmd_count;
  logic [7:0] wr_byte, rx_byte;
  logic       o_Cmd_Ready, o_Cmd_Err, o_Wr_Full, o_Wr_Overflow, o_TX_DV, o_Rd_DV, o_Done, o_Timeout;
  logic [1:0] o_TX_Count;
  logic [7:0] o_TX_Byte, o_Rd_Byte;

  spi_txn_sequencer #(.MAX_BYTES_PER_CS(2), .FIFO_DEPTH(4), .TIMEOUT_CLKS(16)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Cmd_Valid(cmd_valid), .i_Cmd_Count(cmd_count), .o_Cmd_Ready(o_Cmd_Ready), .o_Cmd_Err(o_Cmd_Err),
    .i_Wr_Byte(wr_byte), .i_Wr_DV(wr_dv), .o_Wr_Full(o_Wr_Full), .o_Wr_Overflow(o_Wr_Overflow),
    .o_TX_Count(o_TX_Count), .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV), .i_TX_Ready(tx_ready),
    .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte), .o_Rd_Byte(o_Rd_Byte), .o_Rd_DV(o_Rd_DV),
    .o_Done(o_Done), .o_Timeout(o_Timeout)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, to_cnt = 0, err_cnt = 0, ovf_cnt = 0;
  int first_tx_cyc = 0, tx_cyc = 0, to_cyc = 0, push_cyc = 0, cur_n = 0, dly = 0;
  bit rdy_rand = 0, stub_mute = 0, pend = 0, rx_sent = 0;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] obs_tx[$], obs_rd[$], exp_rd[$], model[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, then play the controller for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (o_TX_DV) begin
      if (obs_tx.size() == 0) first_tx_cyc = cyc;
      obs_tx.push_back(o_TX_Byte);
      tx_cyc = cyc;
    end
    if (o_Rd_DV) obs_rd.push_back(o_Rd_Byte);
    if (o_Done) begin
      done_cnt++;
      check("done_with_last_rd", 32'(o_Rd_DV), 32'd1);
    end
    if (o_Timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (o_Cmd_Err) err_cnt++;
    if (o_Wr_Overflow) ovf_cnt++;
    check("rd_dv_latency", 32'(o_Rd_DV), 32'(rx_sent));
    if (rx_sent) check("rd_byte", 32'(o_Rd_Byte), 32'(rx_last));
    if (!o_Cmd_Ready) check("tx_count_stable", 32'(o_TX_Count), 32'(cur_n));
    cmd_valid = 1'b0;
    wr_dv     = 1'b0;
    rx_dv     = 1'b0;
    rx_sent   = 1'b0;
    tx_ready  = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (o_TX_DV && !stub_mute) begin
      pend = 1'b1;
      dly  = $urandom_range(0, 5);
    end
    if (pend) begin
      if (dly == 0) begin
        rx_dv   = 1'b1;
        rx_byte = 8'($urandom);
        rx_last = rx_byte;
        exp_rd.push_back(rx_byte);
        rx_sent = 1'b1;
        pend    = 1'b0;
      end else begin
        dly--;
      end
    end
  endtask

  task automatic clear_obs();
    obs_tx.delete(); obs_rd.delete(); exp_rd.delete();
    done_cnt = 0; to_cnt = 0; err_cnt = 0; ovf_cnt = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit exp_ovf;
    exp_ovf = (model.size() >= 4);
    if (!exp_ovf) model.push_back(b);
    wr_dv   = 1'b1;
    wr_byte = b;
    push_cyc = cyc + 1;
    step();
    check("wr_overflow", 32'(o_Wr_Overflow), 32'(exp_ovf));
  endtask

  task automatic check_reset_vals();
    check("rst_cmd_ready", 32'(o_Cmd_Ready), 32'd1);
    check("rst_cmd_err", 32'(o_Cmd_Err), 32'd0);
    check("rst_wr_full", 32'(o_Wr_Full), 32'd0);
    check("rst_wr_ovf", 32'(o_Wr_Overflow), 32'd0);
    check("rst_tx_count", 32'(o_TX_Count), 32'd0);
    check("rst_tx_byte", 32'(o_TX_Byte), 32'd0);
    check("rst_tx_dv", 32'(o_TX_DV), 32'd0);
    check("rst_rd_byte", 32'(o_Rd_Byte), 32'd0);
    check("rst_rd_dv", 32'(o_Rd_DV), 32'd0);
    check("rst_done", 32'(o_Done), 32'd0);
    check("rst_timeout", 32'(o_Timeout), 32'd0);
  endtask

  // Issue a command; any bytes the model FIFO lacks are pushed after 'delay' idle cycles.
  task automatic run_cmd(input int n, input int delay, input bit chk_lat);
    logic [7:0] exp_tx[$];
    bit pushed;
    clear_obs();
    pushed = 1'b0;
    if (n >= 1 && n <= 2) cur_n = n;
    cmd_valid = 1'b1;
    cmd_count = 2'(n);
    step();
    if (n < 1 || n > 2) begin
      repeat (3) step();
      check("cmd_err_pulse", 32'(err_cnt), 32'd1);
      check("cmd_err_no_tx", 32'(obs_tx.size()), 32'd0);
      check("cmd_err_ready", 32'(o_Cmd_Ready), 32'd1);
    end else begin
      check("cmd_accept", 32'(o_Cmd_Ready), 32'd0);
      for (int d = 0; d < delay; d++) begin
        if (done_cnt == 0) begin
          cmd_valid = 1'($urandom_range(0, 1));
          cmd_count = 2'($urandom_range(0, 3));
        end
        step();
      end
      while (model.size() < n) begin
        push_byte(8'($urandom));
        pushed = 1'b1;
      end
      for (int i = 0; i < n; i++) exp_tx.push_back(model.pop_front());
      for (int c = 0; c < 200 && done_cnt == 0; c++) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_count = 2'($urandom_range(0, 3));
        step();
      end
      repeat (2) step();
      check("done_once", 32'(done_cnt), 32'd1);
      check("no_timeout", 32'(to_cnt), 32'd0);
      check("no_cmd_err", 32'(err_cnt), 32'd0);
      check("ready_after_done", 32'(o_Cmd_Ready), 32'd1);
      check("tx_pulses", 32'(obs_tx.size()), 32'(n));
      check("rd_pulses", 32'(obs_rd.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
        check("tx_byte", (i < obs_tx.size()) ? 32'(obs_tx[i]) : 32'hDEAD, 32'(exp_tx[i]));
        check("rd_data", (i < obs_rd.size()) ? 32'(obs_rd[i]) : 32'hDEAD,
              (i < exp_rd.size()) ? 32'(exp_rd[i]) : 32'hBEEF);
      end
      check("tx_byte_hold", 32'(o_TX_Byte), 32'(exp_tx[n-1]));
      if (chk_lat && pushed) check("push_to_tx_latency", 32'(first_tx_cyc - push_cyc), 32'd1);
    end
  endtask

  initial begin
    int k, n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_count = 2'd0; wr_byte = 8'd0; wr_dv = 1'b0;
    tx_ready = 1'b1; rx_dv = 1'b0; rx_byte = 8'd0;
    step(); step();
    check_reset_vals();
    rst = 1'b0;
    step();

    // Two-byte transaction
    push_byte(8'hA5); push_byte(8'h3C);
    run_cmd(2, 0, 0);

    // Rejected counts and a stray RX strobe in IDLE
    run_cmd(0, 0, 0);
    run_cmd(3, 0, 0);
    rx_dv = 1'b1; rx_byte = 8'h77;
    step(); step();
    check("stray_rx_idle", 32'(obs_rd.size()), 32'd0);

    // Empty FIFO: command waits, byte pushed 50 cycles later
    run_cmd(1, 50, 1);

    // Fill past depth
    for (int i = 1; i <= 4; i++) begin
      push_byte(8'(i));
      check("wr_full", 32'(o_Wr_Full), 32'(i == 4));
    end
    push_byte(8'h05);
    step();
    check("ovf_one_cycle", 32'(o_Wr_Overflow), 32'd0);
    run_cmd(2, 0, 0);
    run_cmd(2, 0, 0);
    check("fifo_drained", 32'(o_Wr_Full), 32'd0);

    // Timeout with a silent controller
    clear_obs();
    stub_mute = 1'b1;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    cur_n = 2; cmd_valid = 1'b1; cmd_count = 2'd2;
    step();
    for (int c = 0; c < 100 && to_cnt == 0; c++) step();
    repeat (3) step();
    check("timeout_once", 32'(to_cnt), 32'd1);
    check("timeout_one_tx", 32'(obs_tx.size()), 32'd1);
    check("timeout_delay", 32'(to_cyc - tx_cyc), 32'd16);
    check("timeout_no_done", 32'(done_cnt), 32'd0);
    check("timeout_no_rd", 32'(obs_rd.size()), 32'd0);
    check("timeout_idle", 32'(o_Cmd_Ready), 32'd1);
    model.delete();
    stub_mute = 1'b0;
    run_cmd(1, 10, 0);

    // Reset in the middle of a two-byte transaction
    clear_obs();
    push_byte(8'hAA); push_byte(8'hBB);
    cur_n = 2; cmd_valid = 1'b1; cmd_count = 2'd2;
    step();
    for (int c = 0; c < 100 && obs_rd.size() == 0; c++) step();
    check("pre_reset_first_rd", 32'(obs_rd.size()), 32'd1);
    rst = 1'b1; rx_dv = 1'b0; pend = 1'b0; rx_sent = 1'b0;
    step();
    check_reset_vals();
    rst = 1'b0;
    model.delete();
    step();
    check("reset_no_done", 32'(done_cnt), 32'd0);
    run_cmd(1, 5, 0);

    // Randomized traffic
    rdy_rand = 1'b1;
    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(0, 4 - model.size());
      for (int j = 0; j < k; j++) push_byte(8'($urandom));
      check("rand_wr_full", 32'(o_Wr_Full), 32'(model.size() == 4));
      n = $urandom_range(0, 3);
      run_cmd(n, $urandom_range(0, 8), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
